// File: rtl/imem_responder_pkg.sv
// Shared types for the instruction-memory responder.
// Word type and responder FSM states.
package imem_responder_pkg;

  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-side instruction bus between fetch and imem.
// Request/response handshake, redirect flush and load port.
interface imem_responder_if;
  import imem_responder_pkg::*;

  logic req_valid;
  u32   req_addr;
  logic req_ready;
  logic resp_valid;
  u32   resp_data;
  u32   resp_addr;
  logic resp_err;
  logic resp_ready;
  logic flush;
  logic load_en;
  u32   load_addr;
  u32   load_data;

  modport master (
    output req_valid, req_addr, resp_ready,
    output flush, load_en, load_addr, load_data,
    input  req_ready, resp_valid, resp_data,
    input  resp_addr, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    input  flush, load_en, load_addr, load_data,
    output req_ready, resp_valid, resp_data,
    output resp_addr, resp_err
  );

endinterface

// File: rtl/imem_responder_array.sv
// Word array with one sync read and one write port.
// A same-index read and write returns the old word.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output u32                             rd_data,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  u32                             wr_data
);

  u32 mem [DEPTH_WORDS];

  // Read and write at the same edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch,
// fixed latency, flushable, with a side load port.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  imem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  imem_state_t   state;
  logic [CW-1:0] cnt;
  logic          valid_q;
  u32            addr_q;
  logic          err_q;
  logic          data_ok;
  logic          accept;
  logic          req_bad;
  logic          enter_resp;
  logic [AW-1:0] rd_idx;
  u32            rd_data;
  logic          wr_en;

  function automatic logic in_range(u32 a);
    return (a[31:2] >> AW) == '0;
  endfunction

  assign bus.req_ready = !bus.flush &&
    (state == IDLE || (state == RESP && bus.resp_ready));

  assign accept  = bus.req_valid && bus.req_ready;
  assign req_bad = (bus.req_addr[1:0] != 2'b00) ||
                   !in_range(bus.req_addr);

  // The array is read on the edge that moves into RESP.
  assign enter_resp = (accept && LATENCY == 1) ||
    (!bus.flush && state == WAIT && cnt == CW'(1));

  assign rd_idx = (state == WAIT) ? addr_q[2 +: AW]
                                  : bus.req_addr[2 +: AW];

  assign wr_en = bus.load_en && in_range(bus.load_addr);

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rd_en   (enter_resp),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (bus.load_addr[2 +: AW]),
    .wr_data (bus.load_data)
  );

  assign bus.resp_valid = valid_q;
  assign bus.resp_addr  = addr_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_data  = data_ok ? rd_data : '0;

  // Request FSM: flush first, then accept, countdown, handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      data_ok <= 1'b0;
    end else if (bus.flush) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      addr_q <= bus.req_addr;
      err_q  <= req_bad;
      if (LATENCY == 1) begin
        state   <= RESP;
        cnt     <= '0;
        valid_q <= 1'b1;
        data_ok <= !req_bad;
      end else begin
        state   <= WAIT;
        cnt     <= CW'(LATENCY - 1);
        valid_q <= 1'b0;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state   <= RESP;
        valid_q <= 1'b1;
        data_ok <= !err_q;
      end
    end else if (state == RESP && bus.resp_ready) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed cases plus random
// traffic against a cycle-count transaction model.
module tb_imem_responder;
  import imem_responder_pkg::*;

  localparam int DW  = 1024;
  localparam int LAT = 2;
  localparam int AW  = $clog2(DW);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_responder_if bus();

  imem_responder #(
    .DEPTH_WORDS(DW),
    .LATENCY    (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit [31:0] mem [DW];
  bit        m_pend;
  bit [31:0] m_addr;
  bit        m_err;
  bit [31:0] m_data;
  int        m_due;
  int        edges = 0;
  bit        last_acc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_vis();
    return m_pend && edges >= m_due;
  endfunction

  function automatic bit bad_addr(bit [31:0] a);
    return a[1:0] != 2'b00 || a[31:2] >= DW;
  endfunction

  task automatic cyc(input bit iv, input bit [31:0] ia,
                     input bit rr, input bit fl,
                     input bit le, input bit [31:0] la,
                     input bit [31:0] ld);
    bit vis, rdy, hs;
    int k;
    bus.req_valid  = iv;
    bus.req_addr   = ia;
    bus.resp_ready = rr;
    bus.flush      = fl;
    bus.load_en    = le;
    bus.load_addr  = la;
    bus.load_data  = ld;
    #1;
    vis = m_vis();
    rdy = !fl && (!m_pend || (vis && rr));
    chk("req_ready", bus.req_ready, rdy);
    last_acc = iv && rdy;
    hs = vis && rr && !fl;
    k = edges + 1;
    if (fl) m_pend = 0;
    else begin
      if (hs) m_pend = 0;
      if (last_acc) begin
        m_pend = 1;
        m_addr = ia;
        m_err  = bad_addr(ia);
        m_due  = k + LAT - 1;
      end
    end
    if (m_pend && k == m_due)
      m_data = m_err ? 32'h0 : mem[m_addr[2 +: AW]];
    if (le && la[31:2] < DW) mem[la[2 +: AW]] = ld;
    edges = k;
    @(posedge clk);
    #1;
    chk("resp_valid", bus.resp_valid, m_vis());
    if (m_vis()) begin
      chk("resp_data", bus.resp_data, m_data);
      chk("resp_addr", bus.resp_addr, m_addr);
      chk("resp_err", bus.resp_err, m_err);
    end
  endtask

  task automatic idle(input bit rr);
    cyc(0, 0, rr, 0, 0, 0, 0);
  endtask

  task automatic req(input bit [31:0] a, input bit rr);
    cyc(1, a, rr, 0, 0, 0, 0);
  endtask

  task automatic load(input bit [31:0] a, input bit [31:0] d);
    cyc(0, 0, 1, 0, 1, a, d);
  endtask

  initial begin
    int idx, nv, prev;
    bit [31:0] ra, la;
    reset = 1'b0;
    bus.req_valid  = 0;
    bus.req_addr   = 0;
    bus.resp_ready = 1;
    bus.flush      = 0;
    bus.load_en    = 0;
    bus.load_addr  = 0;
    bus.load_data  = 0;
    #2 reset = 1'b1;
    #20;
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_data", bus.resp_data, 0);
    chk("rst_addr", bus.resp_addr, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_ready", bus.req_ready, 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    m_pend = 0;

    for (int i = 0; i < DW; i++) load(i * 4, $urandom);

    load(0, 32'h20080005);
    req(0, 1);
    chk("basic_lat", bus.resp_valid, 0);
    idle(1);
    chk("basic_valid", bus.resp_valid, 1);
    chk("basic_data", bus.resp_data, 32'h20080005);
    chk("basic_addr", bus.resp_addr, 0);
    chk("basic_err", bus.resp_err, 0);
    idle(1);
    chk("basic_done", bus.resp_valid, 0);

    idx = 0;
    nv = 0;
    prev = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(idx < 3, idx * 4, 1, 0, 0, 0, 0);
      if (last_acc) idx++;
      if (bus.resp_valid === 1'b1) begin
        chk("b2b_addr", bus.resp_addr, nv * 4);
        if (nv > 0) chk("b2b_gap", edges - prev, 2);
        prev = edges;
        nv++;
      end
    end
    chk("b2b_count", nv, 3);

    load(32'hC, 32'hCAFE0003);
    req(32'hC, 0);
    idle(0);
    for (int c = 0; c < 5; c++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("bp_data", bus.resp_data, 32'hCAFE0003);
      chk("bp_addr", bus.resp_addr, 32'hC);
      chk("bp_ready", bus.req_ready, 0);
    end
    idle(1);
    chk("bp_done", bus.resp_valid, 0);

    load(32'h10, 32'h44444444);
    load(32'h14, 32'h55555555);
    req(32'h10, 1);
    cyc(0, 0, 1, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      idle(1);
      chk("fl_novalid", bus.resp_valid, 0);
    end
    req(32'h14, 1);
    idle(1);
    chk("fl_valid", bus.resp_valid, 1);
    chk("fl_data", bus.resp_data, 32'h55555555);
    chk("fl_addr", bus.resp_addr, 32'h14);
    idle(1);

    req(32'h2, 1);
    idle(1);
    chk("mis_err", bus.resp_err, 1);
    chk("mis_data", bus.resp_data, 0);
    idle(1);
    req(DW * 4, 1);
    idle(1);
    chk("oor_err", bus.resp_err, 1);
    chk("oor_data", bus.resp_data, 0);
    idle(1);

    req(0, 0);
    idle(0);
    chk("rm_pre", bus.resp_valid, 1);
    reset = 1'b1;
    #2;
    chk("rm_valid", bus.resp_valid, 0);
    chk("rm_data", bus.resp_data, 0);
    chk("rm_addr", bus.resp_addr, 0);
    chk("rm_err", bus.resp_err, 0);
    m_pend = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    req(32'hC, 1);
    idle(1);
    chk("rm_keep", bus.resp_data, 32'hCAFE0003);
    idle(1);

    for (int c = 0; c < 4000; c++) begin
      case ($urandom % 16)
        0: ra = {$urandom_range(0, DW - 1), 2'b00} |
                32'($urandom_range(1, 3));
        1: ra = $urandom | 32'h8000_0000;
        default: ra = {$urandom_range(0, DW - 1), 2'b00};
      endcase
      la = ($urandom % 8 == 0) ? $urandom
         : {$urandom_range(0, DW - 1), 2'($urandom)};
      cyc($urandom % 4 != 0, ra, $urandom % 4 != 0,
          $urandom % 16 == 0, $urandom % 4 == 0, la, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the fetch-side instruction bus. The fetch stage initiates word reads by presenting a PC. This block accepts one request at a time, waits a parameterised latency, and returns the instruction word with a valid/ready handshake. Branch/jump redirects drop any in-flight request through `flush`. A side load port writes program words for simulation and boot.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥2.
- `LATENCY`, 2: cycles from request acceptance to first `resp_valid`; ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fetch presents a read request.
- `req_addr` in 32: byte address (PC).
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `resp_valid` out 1: response held valid.
- `resp_data` out 32: instruction word.
- `resp_addr` out 32: byte address of the request being answered.
- `resp_err` out 1: misaligned or out-of-range request.
- `resp_ready` in 1: fetch consumes the response when `resp_valid && resp_ready` at a rising edge.
- `flush` in 1: redirect; drops the pending request or response.
- `load_en` in 1: write one program word.
- `load_addr` in 32: byte address for the load (bits [1:0] ignored).
- `load_data` in 32: word to write.

## Operation
- FSM states are IDLE, WAIT and RESP. Only one request is outstanding at a time.
- `req_ready` = !flush && (state==IDLE || (state==RESP && resp_ready)).
- **Accept:**
  - Latch `req_addr` into `resp_addr`.
  - Error when `req_addr[1:0]!=0` or `req_addr[31:2] >= DEPTH_WORDS`.
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with `cnt = LATENCY-1`.
- **WAIT:**
  - Decrement `cnt` each cycle.
  - When `cnt==1`, go to RESP.
- **Entering RESP:**
  - Read the array at index `resp_addr[2+AW-1:2]`, where AW = $clog2(DEPTH_WORDS).
  - On error, `resp_data=0` and `resp_err=1`; otherwise `resp_err=0`.
- **RESP:**
  - `resp_valid=1`. `resp_data`, `resp_addr` and `resp_err` hold stable until the handshake.
  - On handshake with a new accept in the same cycle, restart the accept path (back-to-back).
  - On handshake without a new accept, go to IDLE.
- **Flush:**
  - Takes priority over every handshake.
  - From WAIT or RESP, go to IDLE at the next edge and drop `resp_valid`. The flushed request never produces a response.
  - While `flush` is high, nothing is accepted.
- **Load port:**
  - Writes `load_data` to word `load_addr[2+AW-1:2]` at the edge; out-of-range writes are ignored.
  - A load to the word read at the same edge returns the old data (read-before-write).
  - Loads are allowed in any state.
- **Reset:**
  - Outputs: state=IDLE, `cnt=0`, `resp_valid=0`, `resp_data=0`, `resp_addr=0`, `resp_err=0`.
  - Array contents are not reset.
  - Asserting reset mid-operation aborts the request with no response.

## Timing
- All outputs except `req_ready` come from registers. `req_ready` is combinational from state, `resp_ready` and `flush`.
- Accept at edge E0 → `resp_valid` high in the cycle after edge E0+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Sustained throughput with `resp_ready` tied high: one word per LATENCY cycles.
- `flush` seen at edge E → no `resp_valid` in the cycle after E. A request accepted at E+1 is served normally.

## Structure
- `imem_state_t` (IDLE/WAIT/RESP) enum goes in `pipes`.
- `u32` comes from `common`.
- Sub-module `imem_array`:
  - Synchronous single-read, single-write word array, parameterised by DEPTH_WORDS.
  - Read-before-write on the same index.
  - No reset.

## Test plan
- **Basic read:**
  - Load 0x20080005 at word 0; LATENCY=2; request 0x0 with `resp_ready=1`.
  - Expect `resp_valid` 2 cycles after accept, with `resp_data=0x20080005`, `resp_addr=0`, `resp_err=0`.
- **Back-to-back:**
  - Request 0x0, 0x4, 0x8 with `req_valid` held and `resp_ready=1`.
  - Expect three responses in address order, one every 2 cycles, with no gaps beyond LATENCY.
- **Backpressure:**
  - Hold `resp_ready=0` for 5 cycles during RESP.
  - Expect `resp_*` stable and `req_ready=0`. Release → handshake, then return to IDLE.
- **Flush:**
  - Accept 0x10, then pulse `flush` in WAIT.
  - Expect no response for 0x10. A following request to 0x14 returns word 5.
- **Errors:**
  - Request 0x2 → `resp_err=1`, `resp_data=0`.
  - Request `DEPTH_WORDS*4` → `resp_err=1`.
- **Reset mid-op:**
  - Assert `reset` asynchronously in RESP.
  - Expect `resp_valid=0` immediately, all outputs 0, and previously loaded words still readable.
